// File: rtl/alu_pkg.sv
// Shared ALU/arbiter definitions: op codes, flag bit positions, FSM states, request payload.
package alu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned FLAG_W = 4;
    localparam int unsigned REQ_N  = 2;

    localparam logic [OP_W-1:0] ALU_ADD = 3'b000;
    localparam logic [OP_W-1:0] ALU_SUB = 3'b001;
    localparam logic [OP_W-1:0] ALU_AND = 3'b010;
    localparam logic [OP_W-1:0] ALU_OR  = 3'b011;
    localparam logic [OP_W-1:0] ALU_SLT = 3'b101;

    localparam int unsigned FLAG_OV = 0;
    localparam int unsigned FLAG_CO = 1;
    localparam int unsigned FLAG_Z  = 2;
    localparam int unsigned FLAG_N  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OP_W-1:0]   op;
    } alu_req_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Two-requester ALU request/response bus; master = requesters, slave = arbiter.
interface alu_arbiter_if;
    import alu_pkg::*;

    logic [REQ_N-1:0]  req_valid;
    logic [REQ_N-1:0]  req_ready;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic [OP_W-1:0]   req0_op;
    logic [OP_W-1:0]   req1_op;
    logic [REQ_N-1:0]  rsp_valid;
    logic [REQ_N-1:0]  rsp_ready;
    logic [DATA_W-1:0] rsp_res;
    logic [FLAG_W-1:0] rsp_flags;

    modport master (
        output req_valid, req0_a, req0_b, req1_a, req1_b, req0_op, req1_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_res, rsp_flags
    );

    modport slave (
        input  req_valid, req0_a, req0_b, req1_a, req1_b, req0_op, req1_op, rsp_ready,
        output req_ready, rsp_valid, rsp_res, rsp_flags
    );

endinterface

// File: rtl/alu_slt.sv
// Combinational 32-bit ALU (add/sub/and/or/slt) with {neg, zero, cout, ov} flags.
module alu_slt
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] res_c,
    output logic [FLAG_W-1:0] flags_c
);

    logic              is_slt;
    logic              is_sub;
    logic              is_logic;
    logic [DATA_W-1:0] b_eff;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] logic_res;
    logic [DATA_W-1:0] pre;

    // One adder serves add, sub and slt; op[2] only matters for the slt code.
    always_comb begin
        is_slt    = (op == ALU_SLT);
        is_sub    = is_slt || (op[1:0] == ALU_SUB[1:0]);
        is_logic  = !is_slt && ((op[1:0] == ALU_AND[1:0]) || (op[1:0] == ALU_OR[1:0]));
        b_eff     = is_sub ? ~b : b;
        sum       = {1'b0, a} + {1'b0, b_eff} + (DATA_W+1)'(is_sub);
        logic_res = (op[1:0] == ALU_OR[1:0]) ? (a | b) : (a & b);
        pre       = is_logic ? logic_res : sum[DATA_W-1:0];

        flags_c          = '0;
        flags_c[FLAG_N]  = pre[DATA_W-1];
        flags_c[FLAG_Z]  = (pre == '0);
        flags_c[FLAG_CO] = !is_logic && sum[DATA_W];
        flags_c[FLAG_OV] = !is_logic && (a[DATA_W-1] == b_eff[DATA_W-1])
                                     && (sum[DATA_W-1] != a[DATA_W-1]);

        res_c = is_slt ? DATA_W'(flags_c[FLAG_N] ^ flags_c[FLAG_OV]) : pre;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared ALU (IDLE -> EXEC -> RESP).
// Define ALU_ARBITER_RR_EN for round-robin arbitration; fixed priority (req0 wins) otherwise.
module alu_arbiter
    import alu_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);

    arb_state_t        state_q;
    arb_state_t        state_d;
    alu_req_t          req_q;
    alu_req_t          req_sel_c;
    logic              id_q;
    logic              gnt_id_c;
    logic              req_hs_c;
    logic              rsp_hs_c;
    logic [REQ_N-1:0]  req_ready_c;
    logic [REQ_N-1:0]  rsp_valid_q;
    logic [DATA_W-1:0] rsp_res_q;
    logic [FLAG_W-1:0] rsp_flags_q;
    logic [DATA_W-1:0] alu_res_c;
    logic [FLAG_W-1:0] alu_flags_c;

`ifdef ALU_ARBITER_RR_EN
    logic ptr_q;

    // ptr_q names the requester favoured on a simultaneous request.
    always_comb gnt_id_c = (&bus.req_valid) ? ptr_q : !bus.req_valid[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        ptr_q <= 1'b0;
        else if (req_hs_c) ptr_q <= !gnt_id_c;
    end
`else
    always_comb gnt_id_c = !bus.req_valid[0];
`endif

    always_comb req_sel_c = gnt_id_c ? {bus.req1_a, bus.req1_b, bus.req1_op}
                                     : {bus.req0_a, bus.req0_b, bus.req0_op};

    // Next state and combinational grant.
    always_comb begin
        state_d     = state_q;
        req_ready_c = '0;
        req_hs_c    = 1'b0;
        rsp_hs_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (|bus.req_valid) begin
                    req_ready_c = gnt_id_c ? 2'b10 : 2'b01;
                    req_hs_c    = 1'b1;
                    state_d     = EXEC;
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                if (bus.rsp_ready[id_q]) begin
                    rsp_hs_c = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Operand latch and registered response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q       <= '0;
            id_q        <= 1'b0;
            rsp_valid_q <= '0;
            rsp_res_q   <= '0;
            rsp_flags_q <= '0;
        end else begin
            if (req_hs_c) begin
                req_q <= req_sel_c;
                id_q  <= gnt_id_c;
            end
            if (state_q == EXEC) begin
                rsp_valid_q <= id_q ? 2'b10 : 2'b01;
                rsp_res_q   <= alu_res_c;
                rsp_flags_q <= alu_flags_c;
            end else if (rsp_hs_c) begin
                rsp_valid_q <= '0;
            end
        end
    end

    alu_slt u_alu (
        .a       (req_q.a),
        .b       (req_q.b),
        .op      (req_q.op),
        .res_c   (alu_res_c),
        .flags_c (alu_flags_c)
    );

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_res   = rsp_res_q;
    assign bus.rsp_flags = rsp_flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic against a reference model.
// Expected arbitration follows ALU_ARBITER_RR_EN when it is defined for the build.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_arbiter_if bus ();

    alu_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int favour   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Arithmetic reference: flags from plain integer math, slt as signed compare.
    function automatic void ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                                    output logic [31:0] res, output logic [3:0] fl);
        longint sa, sb, sr, sx;
        logic [32:0] w;
        logic [31:0] r;
        logic c, v, slt;
        sa  = $signed(a);
        sb  = $signed(b);
        slt = (op == 3'd5);
        c = 1'b0;
        v = 1'b0;
        if (slt || op[1:0] == 2'd1) begin
            r  = a - b;
            c  = (a >= b);
            sr = sa - sb;
            sx = $signed(r);
            v  = (sr != sx);
        end else if (op[1:0] == 2'd0) begin
            w  = {1'b0, a} + {1'b0, b};
            r  = w[31:0];
            c  = w[32];
            sr = sa + sb;
            sx = $signed(r);
            v  = (sr != sx);
        end else if (op[1:0] == 2'd2) begin
            r = a & b;
        end else begin
            r = a | b;
        end
        fl  = {r[31], (r == 32'd0), c, v};
        res = slt ? {31'b0, (sa < sb)} : r;
    endfunction

    function automatic int pick(input logic [1:0] m);
`ifdef ALU_ARBITER_RR_EN
        if (m == 2'b11) return favour;
`endif
        return m[0] ? 0 : 1;
    endfunction

    // One full transaction starting in an IDLE cycle; returns observed grant and response.
    task automatic run_op(input logic [1:0] m,
                          input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] op0,
                          input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] op1,
                          input int stall, input logic drop,
                          output int obs_g, output logic [31:0] obs_res, output logic [3:0] obs_fl);
        logic [31:0] er;
        logic [3:0]  ef;
        logic [1:0]  oh;
        int g;
        bus.req_valid = m;
        bus.req0_a = a0; bus.req0_b = b0; bus.req0_op = op0;
        bus.req1_a = a1; bus.req1_b = b1; bus.req1_op = op1;
        bus.rsp_ready = 2'b00;
        #1;
        g  = pick(m);
        oh = (g == 0) ? 2'b01 : 2'b10;
        obs_g = bus.req_ready[1] ? 1 : 0;
        check("grant", 32'(bus.req_ready), 32'(oh));
        favour = 1 - g;
        if (g == 0) ref_alu(a0, b0, op0, er, ef);
        else        ref_alu(a1, b1, op1, er, ef);
        step();
        if (drop) bus.req_valid = 2'b00;
        #1;
        check("exec_ready", 32'(bus.req_ready), 32'd0);
        check("exec_valid", 32'(bus.rsp_valid), 32'd0);
        step();
        obs_res = bus.rsp_res;
        obs_fl  = bus.rsp_flags;
        check("rsp_valid", 32'(bus.rsp_valid), 32'(oh));
        check("rsp_res", bus.rsp_res, er);
        check("rsp_flags", 32'(bus.rsp_flags), 32'(ef));
        check("resp_ready", 32'(bus.req_ready), 32'd0);
        for (int i = 0; i < stall; i++) begin
            bus.rsp_ready = ~oh;
            step();
            check("stall_valid", 32'(bus.rsp_valid), 32'(oh));
            check("stall_res", bus.rsp_res, er);
            check("stall_flags", 32'(bus.rsp_flags), 32'(ef));
            check("stall_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = oh;
        step();
        bus.rsp_ready = 2'b00;
        check("rsp_done", 32'(bus.rsp_valid), 32'd0);
    endtask

    task automatic do_reset();
        bus.req_valid = 2'b00;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        favour = 0;
        step();
    endtask

    int          g;
    logic [31:0] r;
    logic [3:0]  f;
    int          exp_seq [4];
    logic [31:0] corner [5];

    initial begin
        corner[0] = 32'h0;          corner[1] = 32'h1;          corner[2] = 32'h7FFF_FFFF;
        corner[3] = 32'h8000_0000;  corner[4] = 32'hFFFF_FFFF;
`ifdef ALU_ARBITER_RR_EN
        exp_seq[0] = 0; exp_seq[1] = 1; exp_seq[2] = 0; exp_seq[3] = 1;
`else
        exp_seq[0] = 0; exp_seq[1] = 0; exp_seq[2] = 0; exp_seq[3] = 0;
`endif
        bus.req_valid = 2'b00; bus.rsp_ready = 2'b00;
        bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
        bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
        rst_n = 1'b0;
        step();
        step();
        check("reset_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_res", bus.rsp_res, 32'd0);
        check("reset_flags", 32'(bus.rsp_flags), 32'd0);
        check("reset_ready", 32'(bus.req_ready), 32'd0);
        rst_n = 1'b1;
        step();

        run_op(2'b01, 32'h7FFF_FFFF, 32'h1, ALU_ADD, 32'h0, 32'h0, ALU_ADD, 0, 1'b1, g, r, f);
        check("add_res", r, 32'h8000_0000);
        check("add_flags", 32'(f), 32'b1001);
        run_op(2'b10, 32'h0, 32'h0, ALU_ADD, 32'h5, 32'h5, ALU_SUB, 0, 1'b1, g, r, f);
        check("sub_res", r, 32'h0);
        check("sub_flags", 32'(f), 32'b0110);
        run_op(2'b01, 32'hFFFF_FFFF, 32'h1, ALU_SLT, 32'h0, 32'h0, ALU_ADD, 0, 1'b1, g, r, f);
        check("slt_res", r, 32'h1);
        check("slt_flags", 32'(f), 32'b1010);

        // Both requesters continuously requesting.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            run_op(2'b11, $urandom, $urandom, ALU_ADD, $urandom, $urandom, ALU_OR, 0, 1'b0, g, r, f);
            check("arb_seq", 32'(g), 32'(exp_seq[i]));
        end

        // Long response backpressure, next grant follows straight away.
        run_op(2'b01, 32'h1234_5678, 32'h0F0F_0F0F, ALU_AND, 32'h0, 32'h0, ALU_ADD, 5, 1'b0, g, r, f);
        run_op(2'b10, 32'h0, 32'h0, ALU_ADD, 32'h8000_0000, 32'h1, 3'b110, 0, 1'b1, g, r, f);

        // Reset asserted mid-EXEC discards the operation.
        bus.req_valid = 2'b01; bus.req0_a = 32'h10; bus.req0_b = 32'h20; bus.req0_op = ALU_ADD;
        step();
        bus.req_valid = 2'b00;
        rst_n = 1'b0;
        #1;
        check("rst_exec_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_exec_res", bus.rsp_res, 32'd0);
        check("rst_exec_flags", 32'(bus.rsp_flags), 32'd0);
        bus.req_valid = 2'b10;
        #1;
        check("rst_exec_idle", 32'(bus.req_ready), 32'b10);
        bus.req_valid = 2'b00;
        step();
        rst_n = 1'b1;
        favour = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        run_op(2'b01, 32'h10, 32'h20, ALU_SLT, 32'h0, 32'h0, ALU_ADD, 1, 1'b0, g, r, f);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] v [4];
            for (int k = 0; k < 4; k++)
                v[k] = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 4)] : 32'($urandom);
            run_op(2'($urandom_range(1, 3)),
                   v[0], v[1], 3'($urandom_range(0, 7)),
                   v[2], v[3], 3'($urandom_range(0, 7)),
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)), g, r, f);
        end

        bus.req_valid = 2'b00;
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameters: none; the datapath width is fixed at 32 bits.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 req_valid  in  2  per-requester request valid; bit i belongs to requester i.
REQ-005 req_ready  out  2  per-requester request accept.
REQ-006 req0_a, req0_b / req1_a, req1_b  in  32 each  operands of requester 0 / 1.
REQ-007 req0_op / req1_op  in  3 each  operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-008 rsp_valid  out  2  one-hot response valid; the bit set selects the owning requester.
REQ-009 rsp_ready  in  2  per-requester response accept.
REQ-010 rsp_res  out  32  registered result.
REQ-011 rsp_flags  out  4  registered flags {neg, zero, cout, ov}.

Function
REQ-012 The FSM SHALL have states IDLE, EXEC and RESP.
REQ-013 IDLE:
- if any req_valid is set, the arbiter SHALL assert req_ready for exactly one granted requester in the same cycle (combinational);
- it SHALL latch that requester's a, b, op and id;
- it SHALL go to EXEC.
REQ-014 EXEC:
- the latched operands SHALL drive the single shared ALU, which has the semantics of alu_slt;
- res and flags SHALL be registered at the end of the cycle;
- the FSM SHALL go to RESP.
REQ-015 RESP:
- rsp_valid[id] SHALL be held high, with rsp_res and rsp_flags stable, until rsp_ready[id]=1;
- on that handshake the FSM SHALL return to IDLE.
REQ-016 Latency: an accept at cycle N SHALL give rsp_valid at N+2. Throughput SHALL be at most one operation per 3 cycles.
REQ-017 req_ready SHALL be 2'b00 in EXEC and RESP, and also in IDLE when req_valid=2'b00.
REQ-018 The rsp_ready bit of the non-owning requester SHALL be ignored.
REQ-019 A requester that deasserts req_valid before its handshake SHALL NOT be granted, and nothing of it SHALL be latched.
REQ-020 op[2] SHALL be ignored except for code 101. The undefined codes 100, 110 and 111 SHALL execute as op[1:0], with no error signalled.
REQ-021 For slt:
- rsp_res SHALL be {31'b0, neg^ov} of the subtraction a-b;
- rsp_flags SHALL be the flags of that subtraction.
REQ-022 Flag rules:
- cout and ov SHALL be 0 for and/or;
- zero and neg SHALL be taken from the add/sub/and/or result before slt substitution.

Reset
REQ-023 On rst_n=0, asynchronously and at any time:
- state SHALL become IDLE;
- rsp_valid=2'b00, rsp_res=0, rsp_flags=0;
- the latched operands, op and id SHALL be cleared;
- the arbitration pointer SHALL be set to favour requester 0.
REQ-024 A reset during EXEC or RESP SHALL discard the in-flight operation; no response SHALL be issued after reset deasserts.

Configuration
REQ-025 Macro ALU_ARBITER_RR_EN, when defined, SHALL select round-robin arbitration:
- on a simultaneous request, the requester not granted last SHALL win;
- the pointer SHALL update only on a request handshake.
REQ-026 When ALU_ARBITER_RR_EN is undefined, arbitration SHALL be fixed priority, with requester 0 always winning a simultaneous request. No pointer register SHALL exist.

Structure
REQ-027 A shared package alu_pkg SHALL hold:
- the op encoding constants (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT);
- the flag bit index constants (FLAG_OV=0, FLAG_CO=1, FLAG_Z=2, FLAG_N=3);
- the FSM state typedef arb_state_t.
REQ-028 The block SHALL instantiate exactly one alu_slt sub-module as the shared ALU. No other arithmetic logic SHALL exist in the block.

Verification
REQ-029 The bench SHALL cover the following scenarios:
- req0 add 0x7FFFFFFF + 0x00000001 -> rsp_valid=01 two cycles after accept, rsp_res=0x80000000, rsp_flags=4'b1001.
- req1 sub 0x00000005 - 0x00000005 -> rsp_valid=10, rsp_res=0, rsp_flags=4'b0110.
- req0 slt a=0xFFFFFFFF, b=0x00000001 -> rsp_res=0x00000001, rsp_flags=4'b1010.
- Both req_valid held high for 4 operations:
  - with ALU_ARBITER_RR_EN, grants SHALL be 0,1,0,1;
  - without it, grants SHALL be 0,0,0,0.
- rsp_ready low for 5 cycles in RESP -> rsp_valid, rsp_res and rsp_flags SHALL stay stable and req_ready=00 throughout; after rsp_ready, the next grant SHALL come in the following IDLE cycle.
- rst_n pulsed low during EXEC -> rsp_valid=00 immediately, state IDLE, no response after release; the next request SHALL complete normally.
